// File: rtl/execute_branch_resolve.sv
// rtl/execute_branch_resolve.sv - branch/jump resolution, mispredict flush, BHT and statistics
//
// Resolves conditional branches and jumps in the execute stage and compares the
// outcome with the fetch-time prediction. A mispredict produces a one-cycle
// registered flush carrying the correct next PC, then a shadow window during
// which execute-stage instructions are ignored. The block also owns the 2-bit
// branch history table that fetch reads, plus saturating statistics counters.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex_vld            execute stage holds a valid instruction
//   inst_branch       conditional branch
//   inst_jump         JAL/JALR, always taken, wins over inst_branch
//   funct3            branch condition
//   alu_dat_out       ALU result (difference for BEQ/BNE, compare result in bit 0 otherwise)
//   br_pred           fetch predicted taken
//   ex_pc, br_target  execute PC and computed taken target
//   fetch_pc          fetch PC for the BHT lookup
//   fetch_pred        BHT prediction for fetch_pc (combinational)
//   flush             one-cycle mispredict flush
//   redirect_pc       correct next PC, valid while flush is high
//   shadow            wrong-path suppression active
//   cnt_clr           synchronous clear of the statistics counters
//   br_cnt, mis_cnt   resolved / mispredicted counts, saturating

module execute_branch_resolve #(
    parameter int PC_W       = 32,
    parameter int DAT_W      = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int SHADOW_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_vld,
    input  logic             inst_branch,
    input  logic             inst_jump,
    input  logic [2:0]       funct3,
    input  logic [DAT_W-1:0] alu_dat_out,
    input  logic             br_pred,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [PC_W-1:0]  br_target,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             fetch_pred,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             shadow,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int SH_W  = $clog2(SHADOW_CYC + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SHADOW = 1'b1;

    // Weakly not-taken: one taken outcome flips the prediction.
    localparam logic [1:0] BHT_INIT = 2'b01;

    logic [0:0]       state_q, state_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic             flush_q, flush_d;
    logic [PC_W-1:0]  redirect_q, redirect_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];

    logic             in_shadow;
    logic             res;
    logic             act;
    logic             mis;
    logic             bht_upd;
    logic             alu_zero;
    logic [PC_W-1:0]  pc_plus4;
    logic [PC_W-1:0]  correct_pc;
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] fetch_idx;

    // Upper/lower PC bits do not take part in the BHT index.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[PC_W-1:2+IDX_W], fetch_pc[1:0]};

    assign in_shadow = (state_q == ST_SHADOW);
    assign res       = ex_vld & ~in_shadow & (inst_branch | inst_jump);
    assign alu_zero  = (alu_dat_out == '0);
    assign pc_plus4  = ex_pc + PC_W'(4);
    assign ex_idx    = ex_pc[2 +: IDX_W];
    assign fetch_idx = fetch_pc[2 +: IDX_W];

    always_comb begin
        act = 1'b0;
        if (inst_jump) begin
            act = 1'b1;
        end else begin
            case (funct3)
                3'b000:  act = alu_zero;
                3'b001:  act = ~alu_zero;
                3'b100,
                3'b110:  act = alu_dat_out[0];
                3'b101,
                3'b111:  act = ~alu_dat_out[0];
                default: act = 1'b0;
            endcase
        end
    end

    assign mis        = res & (act ^ br_pred);
    assign correct_pc = act ? br_target : pc_plus4;
    assign bht_upd    = res & inst_branch & ~inst_jump;

    // Control FSM: a mispredict loads the flush and the shadow window.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        case (state_q)
            ST_IDLE: begin
                if (mis) begin
                    state_d    = ST_SHADOW;
                    sh_cnt_d   = SH_W'(SHADOW_CYC);
                    flush_d    = 1'b1;
                    redirect_d = correct_pc;
                end
            end
            default: begin
                sh_cnt_d = sh_cnt_q - SH_W'(1);
                if (sh_cnt_q == SH_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Only the entry of the resolving branch can change in a cycle.
    always_comb begin
        bht_d = bht_q;
        if (bht_upd) begin
            if (act) begin
                if (bht_q[ex_idx] != 2'b11) begin
                    bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
                end
            end else begin
                if (bht_q[ex_idx] != 2'b00) begin
                    bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
                end
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (cnt_clr) begin
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end else begin
            if (res && (br_cnt_q != '1)) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (mis && (mis_cnt_q != '1)) begin
                mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sh_cnt_q   <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= BHT_INIT;
            end
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    // Read returns the pre-update value when fetch and execute hit the same entry.
    assign fetch_pred  = bht_q[fetch_idx][1];
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign shadow      = in_shadow;
    assign br_cnt      = br_cnt_q;
    assign mis_cnt     = mis_cnt_q;

endmodule

// File: tb/tb_execute_branch_resolve.sv
// tb/tb_execute_branch_resolve.sv - self-checking bench for execute_branch_resolve
module tb_execute_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_vld;
    logic        inst_branch;
    logic        inst_jump;
    logic [2:0]  funct3;
    logic [31:0] alu_dat_out;
    logic        br_pred;
    logic [31:0] ex_pc;
    logic [31:0] br_target;
    logic [31:0] fetch_pc;
    logic        fetch_pred;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        shadow;
    logic        cnt_clr;
    logic [3:0]  br_cnt;
    logic [3:0]  mis_cnt;

    execute_branch_resolve #(
        .PC_W(32), .DAT_W(32), .BHT_DEPTH(64), .SHADOW_CYC(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .ex_vld(ex_vld), .inst_branch(inst_branch),
        .inst_jump(inst_jump), .funct3(funct3), .alu_dat_out(alu_dat_out),
        .br_pred(br_pred), .ex_pc(ex_pc), .br_target(br_target),
        .fetch_pc(fetch_pc), .fetch_pred(fetch_pred), .flush(flush),
        .redirect_pc(redirect_pc), .shadow(shadow), .cnt_clr(cnt_clr),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        flush;
        logic [31:0] pc;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        br;
        logic        jmp;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        exp_act;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic br, input logic jmp, input logic [2:0] f3,
                         input logic [31:0] alu, input logic pred,
                         input logic [31:0] pc, input logic [31:0] tgt);
        ex_vld      = 1'b1;
        inst_branch = br;
        inst_jump   = jmp;
        funct3      = f3;
        alu_dat_out = alu;
        br_pred     = pred;
        ex_pc       = pc;
        br_target   = tgt;
    endtask

    task automatic push_exp(input logic f, input logic [31:0] pc);
        sb_t e;
        e.flush = f;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string name);
        sb_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got flush %0b expected an entry", name, flush);
        end else begin
            n_tests--;
            e = sb_q.pop_front();
            check({name, "_flush"}, 32'(flush), 32'(e.flush));
            if (e.flush) check({name, "_redirect"}, redirect_pc, e.pc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ex_vld = 1'b0; inst_branch = 1'b0; inst_jump = 1'b0; funct3 = 3'b0;
        alu_dat_out = '0; br_pred = 1'b0; ex_pc = '0; br_target = '0;
        fetch_pc = '0; cnt_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected outcome per funct3 for alu values {0, 1, 0xFFFF_FFFE}, bit i = alu value i.
    function automatic logic taken_tbl(input logic [2:0] f3, input int ai);
        logic [2:0] tk;
        case (f3)
            3'b000:  tk = 3'b001;
            3'b001:  tk = 3'b110;
            3'b100,
            3'b110:  tk = 3'b010;
            3'b101,
            3'b111:  tk = 3'b101;
            default: tk = 3'b000;
        endcase
        return tk[ai];
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] alus [3];
        logic        rd_exp [$];
        alus[0] = 32'h0; alus[1] = 32'h1; alus[2] = 32'hFFFF_FFFE;

        for (int f = 0; f < 8; f++) begin
            for (int ai = 0; ai < 3; ai++) begin
                for (int p = 0; p < 2; p++) begin
                    vec_t v;
                    v.br      = 1'b1;
                    v.jmp     = 1'b0;
                    v.f3      = 3'(f);
                    v.alu     = alus[ai];
                    v.pred    = p[0];
                    v.pc      = 32'h1000 + 32'(vecs.size() * 8);
                    v.tgt     = 32'h3000 + 32'(vecs.size() * 16);
                    v.exp_act = taken_tbl(3'(f), ai);
                    vecs.push_back(v);
                end
            end
        end

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_redirect", redirect_pc, 32'h0);
        check("rst_shadow", 32'(shadow), 32'h0);
        check("rst_br_cnt", 32'(br_cnt), 32'h0);
        check("rst_mis_cnt", 32'(mis_cnt), 32'h0);
        for (int i = 0; i < 64; i++) begin
            fetch_pc = 32'(i * 4);
            #1;
            check("rst_fetch_pred", 32'(fetch_pred), 32'h0);
        end

        // First mispredict and shadow timing
        drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b0, 32'h100, 32'h200);
        push_exp(1'b1, 32'h200);
        @(negedge clk);
        ex_vld = 1'b0;
        sb_check("beq_first");
        check("first_shadow0", 32'(shadow), 32'h1);
        check("first_mis_cnt", 32'(mis_cnt), 32'h1);
        check("first_br_cnt", 32'(br_cnt), 32'h1);
        @(negedge clk);
        check("first_shadow1", 32'(shadow), 32'h1);
        check("first_flush_pulse", 32'(flush), 32'h0);
        @(negedge clk);
        check("first_shadow_end", 32'(shadow), 32'h0);

        // Table sweep over all conditions
        foreach (vecs[i]) begin
            logic ef;
            ef = vecs[i].exp_act ^ vecs[i].pred;
            drive(vecs[i].br, vecs[i].jmp, vecs[i].f3, vecs[i].alu, vecs[i].pred,
                  vecs[i].pc, vecs[i].tgt);
            push_exp(ef, vecs[i].exp_act ? vecs[i].tgt : vecs[i].pc + 32'd4);
            @(negedge clk);
            ex_vld = 1'b0;
            sb_check($sformatf("sweep_f%0d_a%0h_p%0b", vecs[i].f3, vecs[i].alu, vecs[i].pred));
            @(negedge clk);
            @(negedge clk);
        end

        // PC wrap-around, then a shadowed mispredict is dropped
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 32'h1, 1'b1, 32'hFFFF_FFFC, 32'h500);
        push_exp(1'b1, 32'h0);
        @(negedge clk);
        sb_check("wrap");
        drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b0, 32'h600, 32'h700);
        push_exp(1'b0, 32'h0);
        @(negedge clk);
        ex_vld = 1'b0;
        sb_check("shadow_drop");
        check("shadow_drop_mis_cnt", 32'(mis_cnt), 32'h1);
        check("shadow_drop_br_cnt", 32'(br_cnt), 32'h1);
        @(negedge clk);

        // Statistics saturation and clear priority
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b1, 32'h2000, 32'h2400);
            @(negedge clk);
        end
        ex_vld = 1'b0;
        check("br_cnt_sat", 32'(br_cnt), 32'hF);
        check("mis_cnt_zero", 32'(mis_cnt), 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b0, 32'h2100, 32'h2200);
        cnt_clr = 1'b1;
        push_exp(1'b1, 32'h2200);
        @(negedge clk);
        ex_vld = 1'b0;
        cnt_clr = 1'b0;
        sb_check("clr_mis");
        check("clr_br_cnt", 32'(br_cnt), 32'h0);
        check("clr_mis_cnt", 32'(mis_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);

        // BHT training at 0x40 with fetch reading the same index
        do_reset();
        fetch_pc = 32'h40;
        rd_exp = '{1'b0, 1'b1, 1'b1};
        foreach (rd_exp[i]) begin
            drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b1, 32'h40, 32'h80);
            #1;
            check($sformatf("bht_taken_rd%0d", i), 32'(fetch_pred), 32'(rd_exp[i]));
            @(negedge clk);
        end
        ex_vld = 1'b0;
        #1;
        check("bht_sat3", 32'(fetch_pred), 32'h1);
        @(negedge clk);
        rd_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        foreach (rd_exp[i]) begin
            drive(1'b1, 1'b0, 3'b000, 32'h1, 1'b0, 32'h40, 32'h80);
            #1;
            check($sformatf("bht_nt_rd%0d", i), 32'(fetch_pred), 32'(rd_exp[i]));
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b1, 32'h40, 32'h80);
        #1;
        check("bht_sat0", 32'(fetch_pred), 32'h0);
        @(negedge clk);
        // Entry is now 1; a jump (with branch also set) must leave it alone.
        drive(1'b1, 1'b1, 3'b001, 32'h0, 1'b1, 32'h40, 32'h80);
        @(negedge clk);
        ex_vld = 1'b0;
        check("jump_no_flush", 32'(flush), 32'h0);
        #1;
        check("jump_no_bht", 32'(fetch_pred), 32'h0);
        @(negedge clk);

        // Reset in the middle of the shadow window
        drive(1'b1, 1'b0, 3'b000, 32'h0, 1'b1, 32'h40, 32'h80);
        @(negedge clk);
        ex_vld = 1'b0;
        #1;
        check("trained_pred", 32'(fetch_pred), 32'h1);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b000, 32'h1, 1'b1, 32'h300, 32'h900);
        push_exp(1'b1, 32'h304);
        @(negedge clk);
        ex_vld = 1'b0;
        sb_check("pre_rst_mis");
        check("pre_rst_shadow", 32'(shadow), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_shadow", 32'(shadow), 32'h0);
        check("rst_mid_flush", 32'(flush), 32'h0);
        #1;
        check("rst_mid_bht", 32'(fetch_pred), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
